// File: rtl/leitor_caminho_pkg.sv
// ---------------------------------------------------------------------------
// leitor_caminho_pkg
// Shared definitions for the path reader and the path controller it talks to:
//   - default widths for node addresses and path indices
//   - default wait limit while the controller builds a path
//   - the 3-bit state encoding of the reader FSM
// No ports (package).
// ---------------------------------------------------------------------------
package leitor_caminho_pkg;

    // Default node address width.
    localparam int ADDR_W_PADRAO  = 12;

    // Default path index width; a path holds at most 2^IDX_W-1 nodes.
    localparam int IDX_W_PADRAO   = 8;

    // Default number of cycles to wait for a built path; 0 means wait forever.
    localparam int TIMEOUT_PADRAO = 65535;

    // Reader FSM states, fixed 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INICIAR  = 3'd1,
        ST_AGUARDAR = 3'd2,
        ST_LER      = 3'd3,
        ST_ENVIAR   = 3'd4,
        ST_LIDO     = 3'd5
    } estado_t;

endpackage

// File: rtl/leitor_caminho.sv
// ---------------------------------------------------------------------------
// leitor_caminho
// Accepts a (source, destination) request from a host, starts the path
// controller, waits for the built path and then streams every node of the
// path out of the path memory over a valid/ready interface.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req_valid_in/ready_out host request handshake
//   req_fonte_in/destino_in requested source / destination node
//   aguardando_in          path controller is idle
//   iniciar_out            one-cycle start pulse to the controller
//   fonte_out/destino_out  registered source / destination for the controller
//   caminho_pronto_in      path built (held until lido_out)
//   caminho_tamanho_in     node count of the built path
//   lido_out               one-cycle "path consumed" pulse
//   mem_rd_en_out/addr_out path memory read strobe and index
//   mem_data_in            path memory read data, one cycle after the strobe
//   no_valid_out/ready_in  node stream handshake
//   no_data_out            node address
//   no_last_out            final node of the path
//   sem_caminho_out        one-cycle pulse: path of length zero
//   erro_out               one-cycle pulse: controller did not answer in time
// ---------------------------------------------------------------------------
module leitor_caminho
    import leitor_caminho_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_PADRAO,
    parameter int IDX_W          = IDX_W_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [ADDR_W-1:0] req_fonte_in,
    input  logic [ADDR_W-1:0] req_destino_in,

    input  logic              aguardando_in,
    output logic              iniciar_out,
    output logic [ADDR_W-1:0] fonte_out,
    output logic [ADDR_W-1:0] destino_out,
    input  logic              caminho_pronto_in,
    input  logic [IDX_W-1:0]  caminho_tamanho_in,
    output logic              lido_out,

    output logic              mem_rd_en_out,
    output logic [IDX_W-1:0]  mem_addr_out,
    input  logic [ADDR_W-1:0] mem_data_in,

    output logic              no_valid_out,
    input  logic              no_ready_in,
    output logic [ADDR_W-1:0] no_data_out,
    output logic              no_last_out,

    output logic              sem_caminho_out,
    output logic              erro_out
);

    // The wait counter only has to reach TIMEOUT_CICLOS-1, so clog2 bits
    // are enough; keep at least one bit when the limit is 0 or 1.
    localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam bit TIMEOUT_ATIVO = (TIMEOUT_CICLOS != 0);
    localparam logic [CNT_W-1:0] LIMITE =
        (TIMEOUT_CICLOS > 0) ? CNT_W'(TIMEOUT_CICLOS - 1) : '0;

    estado_t           r_estado;
    logic [CNT_W-1:0]  r_espera;
    logic [IDX_W-1:0]  r_indice;
    logic [IDX_W-1:0]  r_tamanho;
    logic [ADDR_W-1:0] r_fonte;
    logic [ADDR_W-1:0] r_destino;
    logic [ADDR_W-1:0] r_noData;
    logic              r_primeiro;
    logic              r_noValid;
    logic              r_noLast;
    logic              r_iniciar;
    logic              r_lido;
    logic              r_memRdEn;
    logic              r_semCaminho;
    logic              r_erro;

    logic              w_reqAceito;
    logic              w_ultimo;

    // A request can only be taken while we are idle and the controller is
    // free, so the host never starts a path the controller cannot build.
    assign req_ready_out = (r_estado == ST_IDLE) && aguardando_in;
    assign w_reqAceito   = req_valid_in && req_ready_out;

    // The index is the last one of the path; evaluated before any increment,
    // which is why the index can never wrap.
    assign w_ultimo = (r_indice == (r_tamanho - IDX_W'(1)));

    // Main FSM. Every output is a register that is set on the transition
    // into the state it belongs to, so each pulse lines up exactly with its
    // state. Pulse registers default to 0 and are only raised on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado     <= ST_IDLE;
            r_espera     <= '0;
            r_indice     <= '0;
            r_tamanho    <= '0;
            r_fonte      <= '0;
            r_destino    <= '0;
            r_noData     <= '0;
            r_primeiro   <= 1'b0;
            r_noValid    <= 1'b0;
            r_noLast     <= 1'b0;
            r_iniciar    <= 1'b0;
            r_lido       <= 1'b0;
            r_memRdEn    <= 1'b0;
            r_semCaminho <= 1'b0;
            r_erro       <= 1'b0;
        end else begin
            r_iniciar    <= 1'b0;
            r_lido       <= 1'b0;
            r_memRdEn    <= 1'b0;
            r_semCaminho <= 1'b0;
            r_erro       <= 1'b0;
            r_primeiro   <= 1'b0;

            case (r_estado)
                ST_IDLE: begin
                    if (w_reqAceito) begin
                        r_fonte   <= req_fonte_in;
                        r_destino <= req_destino_in;
                        r_iniciar <= 1'b1;
                        r_estado  <= ST_INICIAR;
                    end
                end

                ST_INICIAR: begin
                    r_espera <= '0;
                    r_estado <= ST_AGUARDAR;
                end

                ST_AGUARDAR: begin
                    // A finished path beats a timeout in the same cycle.
                    if (caminho_pronto_in) begin
                        r_tamanho <= caminho_tamanho_in;
                        r_indice  <= '0;
                        if (caminho_tamanho_in == '0) begin
                            r_semCaminho <= 1'b1;
                            r_lido       <= 1'b1;
                            r_estado     <= ST_LIDO;
                        end else begin
                            r_memRdEn <= 1'b1;
                            r_estado  <= ST_LER;
                        end
                    end else if (TIMEOUT_ATIVO && (r_espera == LIMITE)) begin
                        r_erro   <= 1'b1;
                        r_estado <= ST_IDLE;
                    end else begin
                        r_espera <= r_espera + 1'b1;
                    end
                end

                ST_LER: begin
                    r_primeiro <= 1'b1;
                    r_noValid  <= 1'b1;
                    r_noLast   <= w_ultimo;
                    r_estado   <= ST_ENVIAR;
                end

                ST_ENVIAR: begin
                    // Memory data only arrives in the first ENVIAR cycle;
                    // hold it so the node stays stable through a stall.
                    if (r_primeiro) begin
                        r_noData <= mem_data_in;
                    end
                    if (no_ready_in) begin
                        r_noValid <= 1'b0;
                        r_noLast  <= 1'b0;
                        if (r_noLast) begin
                            r_lido   <= 1'b1;
                            r_estado <= ST_LIDO;
                        end else begin
                            r_indice  <= r_indice + IDX_W'(1);
                            r_memRdEn <= 1'b1;
                            r_estado  <= ST_LER;
                        end
                    end
                end

                ST_LIDO: begin
                    r_estado <= ST_IDLE;
                end

                default: begin
                    r_estado <= ST_IDLE;
                end
            endcase
        end
    end

    // In the first ENVIAR cycle the node comes straight from the memory read
    // port (its own output register), so a node can leave every two cycles;
    // afterwards the captured copy is shown.
    assign no_data_out     = r_primeiro ? mem_data_in : r_noData;

    assign iniciar_out     = r_iniciar;
    assign fonte_out       = r_fonte;
    assign destino_out     = r_destino;
    assign lido_out        = r_lido;
    assign mem_rd_en_out   = r_memRdEn;
    assign mem_addr_out    = r_indice;
    assign no_valid_out    = r_noValid;
    assign no_last_out     = r_noLast;
    assign sem_caminho_out = r_semCaminho;
    assign erro_out        = r_erro;

endmodule

// File: doc/leitor_caminho.md
LEITOR_CAMINHO -- requirements
Module: leitor_caminho

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: node address width.
REQ-002 SHALL have parameter IDX_W, default 8: path index width (max 2^IDX_W-1 nodes).
REQ-003 SHALL have parameter TIMEOUT_CICLOS, default 65535: wait limit in ST_AGUARDAR; 0 disables it.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid_in  in  1  host request valid
- req_ready_out  out  1  request accepted when both high
- req_fonte_in  in  ADDR_W  source node
- req_destino_in  in  ADDR_W  destination node
- aguardando_in  in  1  path controller idle
- iniciar_out  out  1  start pulse to controller
- fonte_out  out  ADDR_W  registered source
- destino_out  out  ADDR_W  registered destination
- caminho_pronto_in  in  1  path built, held until lido
- caminho_tamanho_in  in  IDX_W  path node count, valid with caminho_pronto_in
- lido_out  out  1  path consumed pulse
- mem_rd_en_out  out  1  path memory read strobe
- mem_addr_out  out  IDX_W  path memory index
- mem_data_in  in  ADDR_W  read data, 1-cycle latency
- no_valid_out  out  1  output node valid
- no_ready_in  in  1  downstream ready
- no_data_out  out  ADDR_W  node address
- no_last_out  out  1  final node of path
- sem_caminho_out  out  1  pulse: zero-length path
- erro_out  out  1  pulse: timeout

Function
REQ-006 FSM states SHALL be ST_IDLE, ST_INICIAR, ST_AGUARDAR, ST_LER, ST_ENVIAR, ST_LIDO.
REQ-007 req_ready_out SHALL equal (state==ST_IDLE && aguardando_in).
REQ-008 On request handshake, fonte_out/destino_out SHALL register the inputs and the FSM SHALL go to ST_INICIAR.
REQ-009 iniciar_out SHALL be high for exactly one cycle, in ST_INICIAR. The next state SHALL be ST_AGUARDAR with the timeout counter cleared.
REQ-010 In ST_AGUARDAR, caminho_pronto_in SHALL latch caminho_tamanho_in into a length register and clear the index to 0.
- Length 0: next state ST_LIDO, and sem_caminho_out pulses in the same cycle as the transition.
- Otherwise: next state ST_LER.
REQ-011 If TIMEOUT_CICLOS≠0 and the counter reaches TIMEOUT_CICLOS-1 without caminho_pronto_in, erro_out SHALL pulse for one cycle and the FSM SHALL return to ST_IDLE without lido_out.
REQ-012 If caminho_pronto_in and the timeout occur in the same cycle, caminho_pronto_in SHALL win.
REQ-013 ST_LER SHALL assert mem_rd_en_out for one cycle with mem_addr_out=index, then go to ST_ENVIAR. In the first ST_ENVIAR cycle, no_data_out SHALL register mem_data_in.
REQ-014 In ST_ENVIAR, no_valid_out SHALL be high. no_data_out and no_last_out SHALL stay stable until no_ready_in.
REQ-015 no_last_out SHALL be high iff index==length-1.
REQ-016 On the output handshake:
- Last node: next state ST_LIDO.
- Otherwise: index increments and next state ST_LER.
- Throughput is therefore one node per 2 cycles when no_ready_in is high.
REQ-017 ST_LIDO SHALL hold lido_out high for exactly one cycle, then return to ST_IDLE.
REQ-018 A request presented while aguardando_in is low SHALL NOT be accepted; req_valid_in SHALL be ignored outside ST_IDLE.
REQ-019 Index and length arithmetic SHALL be unsigned IDX_W-bit. The index SHALL never wrap, because the terminal check precedes the increment.
REQ-020 caminho_pronto_in outside ST_AGUARDAR SHALL be ignored.

Reset
REQ-021 Assertion of rst SHALL asynchronously force:
- the FSM to ST_IDLE;
- all outputs to 0, except req_ready_out, which follows REQ-007;
- all counters and registers to 0.
REQ-022 Reset mid-transfer SHALL abandon the path with no lido_out and no further no_valid_out.

Structure
REQ-023 A shared package SHALL hold the state encoding (3-bit), the ADDR_W/IDX_W defaults and the TIMEOUT_CICLOS default; the package is also used by the path controller.
REQ-024 SHALL be a single module with no sub-modules. The timeout counter and index counter are inline.

Verification
REQ-025 Fonte=5, destino=40, pronto after 10 cycles, length=3, memory {40,17,5}, no_ready_in=1 -> one iniciar_out pulse; nodes 40,17,5 with no_last_out only on 5; one lido_out.
REQ-026 Length=0 -> sem_caminho_out and lido_out pulses; no_valid_out never high.
REQ-027 Length=4 with no_ready_in toggling 1 of every 3 cycles -> no_data_out stable while stalled; 4 handshakes; order preserved.
REQ-028 TIMEOUT_CICLOS=20, caminho_pronto_in never asserted -> erro_out at cycle 20 of ST_AGUARDAR; back to ST_IDLE; a new request is then accepted.
REQ-029 req_valid_in=1 with aguardando_in=0 -> req_ready_out=0 and no iniciar_out; later set aguardando_in=1 -> accepted the same cycle.
REQ-030 rst asserted during the second node of a length-5 path -> outputs 0 immediately; no lido_out; a subsequent request completes normally.
